// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-hazard scoreboard: register count,
// index type and the pending-counter ceiling helper.
package reg_scoreboard_pkg;

    localparam int GLB_REG_NUM = 31;
    localparam int SB_NUM_REGS = GLB_REG_NUM + 1;
    localparam int SB_IDX_W    = $clog2(SB_NUM_REGS);

    typedef logic [SB_IDX_W-1:0] reg_idx_t;

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register saturating pending-write counter with a sticky underflow flag.
// Claims and releases of the same cycle are merged into one signed update.
module sb_counter #(
    parameter int CNT_W = 2,
    parameter int REL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic [1:0]       i_inc,
    input  logic [REL_W-1:0] i_rel,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_err
);

    localparam int SUM_W = ((CNT_W > REL_W) ? CNT_W : REL_W) + 2;
    localparam logic [SUM_W-1:0] MAX_V = SUM_W'((1 << CNT_W) - 1);

    logic [SUM_W-1:0] w_add;
    logic [SUM_W-1:0] w_rel;
    logic [SUM_W-1:0] w_diff;
    logic             w_under;
    logic [CNT_W-1:0] w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_err;

    // Net claims minus releases, clamped into [0, MAX_V]
    always_comb begin
        w_add   = SUM_W'(r_cnt) + SUM_W'(i_inc);
        w_rel   = SUM_W'(i_rel);
        w_diff  = w_add - w_rel;
        w_under = (w_add < w_rel);
        if (w_under) begin
            w_nxt = '0;
        end else if (w_diff > MAX_V) begin
            w_nxt = CNT_W'(MAX_V);
        end else begin
            w_nxt = CNT_W'(w_diff);
        end
    end

    // Counter state; flush wins over any same-cycle claim or release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else if (i_flush) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_err  <= r_err;
        end else begin
            r_cnt  <= w_nxt;
            r_busy <= (w_nxt != '0);
            r_err  <= r_err | w_under;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = r_busy;
    assign o_err  = r_err;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between Decode and Data-Fetch/Schedule.
// Optional macro SCOREBOARD_BYPASS_EN: a source retiring on this cycle's writeback bus is not a hazard.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = 2,
    parameter int NUM_SRC  = 3,
    parameter int NUM_WB   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chk_valid,
    input  logic [NUM_SRC-1:0]        chk_src_en,
    input  logic [NUM_SRC*IDX_W-1:0]  chk_src,
    input  logic [1:0]                chk_dst_en,
    input  logic [2*IDX_W-1:0]        chk_dst,
    output logic                      chk_ok,
    input  logic                      issue,
    input  logic [NUM_WB-1:0]         wb_en,
    input  logic [NUM_WB*IDX_W-1:0]   wb_reg,
    input  logic                      flush,
    output logic [NUM_REGS-1:0]       busy_mask,
    output logic                      idle,
    output logic                      err
);

    localparam int REL_W   = $clog2(NUM_WB + 1);
    localparam int CMP_W   = ((CNT_W > REL_W) ? CNT_W : REL_W) + 2;
    localparam int CNT_MAX = cnt_max(CNT_W);

    logic [CNT_W-1:0]    w_cnt   [NUM_REGS];
    logic [1:0]          w_claim [NUM_REGS];
    logic [REL_W-1:0]    w_rel   [NUM_REGS];
    logic [NUM_REGS-1:0] w_src_blk;
    logic [NUM_REGS-1:0] w_sat;
    logic [NUM_REGS-1:0] w_err;
    logic                w_dup;
    logic                w_src_haz;
    logic                w_fire;

    // Per-register claim/release decode, source blocking and saturation test
    always_comb begin
        w_dup = chk_dst_en[0] & chk_dst_en[1] &
                (chk_dst[0 +: IDX_W] == chk_dst[IDX_W +: IDX_W]);
        for (int r = 0; r < NUM_REGS; r++) begin
            w_claim[r] = 2'(chk_dst_en[0] && (chk_dst[0 +: IDX_W] == IDX_W'(r))) +
                         2'(chk_dst_en[1] && (chk_dst[IDX_W +: IDX_W] == IDX_W'(r)) && !w_dup);
            w_rel[r] = '0;
            for (int w = 0; w < NUM_WB; w++) begin
                w_rel[r] = w_rel[r] + REL_W'(wb_en[w] && (wb_reg[w*IDX_W +: IDX_W] == IDX_W'(r)));
            end
`ifdef SCOREBOARD_BYPASS_EN
            w_src_blk[r] = (CMP_W'(w_cnt[r]) != CMP_W'(w_rel[r]));
`else
            w_src_blk[r] = (w_cnt[r] != '0);
`endif
            w_sat[r] = (CMP_W'(w_cnt[r]) + CMP_W'(w_claim[r])) > CMP_W'(CNT_MAX);
        end
    end

    // Source hazard reduction across the enabled operand slots
    always_comb begin
        w_src_haz = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_src_haz = w_src_haz | (chk_src_en[s] & w_src_blk[chk_src[s*IDX_W +: IDX_W]]);
        end
    end

    assign chk_ok = chk_valid & ~flush & ~reset & ~w_src_haz & ~(|w_sat);
    assign w_fire = chk_ok & issue;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W),
            .REL_W (REL_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_flush (flush),
            .i_inc   (w_fire ? w_claim[g] : 2'd0),
            .i_rel   (w_rel[g]),
            .o_cnt   (w_cnt[g]),
            .o_busy  (busy_mask[g]),
            .o_err   (w_err[g])
        );
    end

    assign idle = ~(|busy_mask);
    assign err  = |w_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed test-plan steps plus a
// randomized phase, all checked against a per-register integer count model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int NR   = 32;
    localparam int IW   = 5;
    localparam int MAXC = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           chk_valid;
    logic [2:0]     chk_src_en;
    logic [3*IW-1:0] chk_src;
    logic [1:0]     chk_dst_en;
    logic [2*IW-1:0] chk_dst;
    logic           chk_ok;
    logic           issue;
    logic [1:0]     wb_en;
    logic [2*IW-1:0] wb_reg;
    logic           flush;
    logic [NR-1:0]  busy_mask;
    logic           idle;
    logic           err;

    int m_cnt [NR];
    bit m_err;
    int n_tests = 0;
    int n_fail  = 0;

    reg_scoreboard #(
        .NUM_REGS (NR), .IDX_W (IW), .CNT_W (2), .NUM_SRC (3), .NUM_WB (2)
    ) dut (
        .clk (clk), .reset (reset), .chk_valid (chk_valid), .chk_src_en (chk_src_en),
        .chk_src (chk_src), .chk_dst_en (chk_dst_en), .chk_dst (chk_dst), .chk_ok (chk_ok),
        .issue (issue), .wb_en (wb_en), .wb_reg (wb_reg), .flush (flush),
        .busy_mask (busy_mask), .idle (idle), .err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int src_of(int s);
        return int'(chk_src[s*IW +: IW]);
    endfunction

    function automatic int dst_of(int d);
        return int'(chk_dst[d*IW +: IW]);
    endfunction

    // Number of distinct enabled destinations naming register r
    function automatic int claims_of(int r);
        int c = 0;
        if (chk_dst_en[0] && dst_of(0) == r) c++;
        if (chk_dst_en[1] && dst_of(1) == r &&
            !(chk_dst_en[0] && dst_of(0) == dst_of(1))) c++;
        return c;
    endfunction

    function automatic int rel_of(int r);
        int c = 0;
        for (int w = 0; w < 2; w++)
            if (wb_en[w] && int'(wb_reg[w*IW +: IW]) == r) c++;
        return c;
    endfunction

    function automatic bit model_ok();
        if (!chk_valid || flush || reset) return 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (chk_src_en[s]) begin
`ifdef SCOREBOARD_BYPASS_EN
                if (m_cnt[src_of(s)] != rel_of(src_of(s))) return 1'b0;
`else
                if (m_cnt[src_of(s)] != 0) return 1'b0;
`endif
            end
        end
        for (int d = 0; d < 2; d++)
            if (chk_dst_en[d] && m_cnt[dst_of(d)] + claims_of(dst_of(d)) > MAXC) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear(input bit clr_err);
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        if (clr_err) m_err = 1'b0;
    endtask

    task automatic model_update(input bit fire);
        int v;
        if (flush) begin
            model_clear(1'b0);
        end else begin
            for (int r = 0; r < NR; r++) begin
                v = m_cnt[r] + (fire ? claims_of(r) : 0) - rel_of(r);
                if (v < 0) begin
                    v = 0;
                    m_err = 1'b1;
                end
                if (v > MAXC) v = MAXC;
                m_cnt[r] = v;
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [NR-1:0] exp_busy;
        for (int r = 0; r < NR; r++) exp_busy[r] = (m_cnt[r] != 0);
        check({tag, ".busy"}, busy_mask, exp_busy);
        check({tag, ".idle"}, idle, exp_busy == '0);
        check({tag, ".err"}, err, m_err);
    endtask

    // One cycle: check the combinational grant, advance the model, check state
    task automatic step(input string tag);
        bit exp_ok;
        #1;
        exp_ok = model_ok();
        check({tag, ".ok"}, chk_ok, exp_ok);
        model_update(exp_ok && issue);
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic uop(input bit v, input logic [2:0] sen, input int s0, input int s1,
                       input int s2, input logic [1:0] den, input int d0, input int d1,
                       input bit iss);
        chk_valid  = v;
        chk_src_en = sen;
        chk_src    = {reg_idx_t'(s2), reg_idx_t'(s1), reg_idx_t'(s0)};
        chk_dst_en = den;
        chk_dst    = {reg_idx_t'(d1), reg_idx_t'(d0)};
        issue      = iss;
    endtask

    task automatic wb(input logic [1:0] en, input int r0, input int r1);
        wb_en  = en;
        wb_reg = {reg_idx_t'(r1), reg_idx_t'(r0)};
    endtask

    task automatic idle_in();
        uop(1'b0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1'b0);
        wb(2'b00, 0, 0);
        flush = 1'b0;
    endtask

    task automatic do_flush();
        idle_in();
        flush = 1'b1;
        step("flush");
        flush = 1'b0;
    endtask

    initial begin
        int r0, r1;
        bit e0, e1;
        reset = 1'b1;
        idle_in();
        model_clear(1'b1);
        uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 1, 0, 1'b1);
        #1;
        check("rst.ok", chk_ok, 1'b0);
        check_state("rst");
        @(negedge clk);
        reset = 1'b0;
        idle_in();

        // RAW on r5
        uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 1'b1);
        step("raw.fire");
        uop(1'b1, 3'b001, 5, 0, 0, 2'b00, 0, 0, 1'b0);
        step("raw.block");
        wb(2'b01, 5, 0);
        step("raw.wb");
        wb(2'b00, 0, 0);
        step("raw.free");
        check("raw.ok_direct", chk_ok, 1'b1);

        // Multi-writer on r7 up to saturation
        for (int i = 0; i < 3; i++) begin
            uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 1'b1);
            step("multi.fire");
        end
        step("multi.sat");
        uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 1'b0);
        wb(2'b01, 7, 0);
        step("multi.wb");
        wb(2'b00, 0, 0);
        step("multi.free");
        do_flush();

        // Dual destinations
        uop(1'b1, 3'b000, 0, 0, 0, 2'b11, 0, 4, 1'b1);
        step("dual.fire");
        check("dual.mask", busy_mask, 32'h0000_0011);
        do_flush();
        uop(1'b1, 3'b000, 0, 0, 0, 2'b11, 4, 4, 1'b1);
        step("dual.same");
        idle_in();
        wb(2'b01, 4, 0);
        step("dual.rel");

        // Simultaneous claim and release on r2
        idle_in();
        uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 2, 0, 1'b1);
        step("sim.fire");
        wb(2'b01, 2, 0);
        step("sim.net0");
        wb(2'b00, 0, 0);
        step("sim.fire2");
        idle_in();
        wb(2'b11, 2, 2);
        step("sim.dualwb");
        check("sim.idle_direct", idle, 1'b1);

        // Randomized traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            uop(($urandom % 4) != 0, 3'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                ($urandom % 3) != 0);
            r0 = $urandom_range(0, 7);
            r1 = $urandom_range(0, 7);
            e0 = (m_cnt[r0] > 0) && ($urandom % 2 == 1);
            e1 = (m_cnt[r1] > ((e0 && r1 == r0) ? 1 : 0)) && ($urandom % 2 == 1);
            wb({e1, e0}, r0, r1);
            flush = ($urandom % 25) == 0;
            step("rand");
        end
        do_flush();

        // Flush discards a fire; later underflow sets sticky err
        uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 9, 0, 1'b1);
        flush = 1'b1;
        step("fl.fire");
        idle_in();
        wb(2'b01, 9, 0);
        step("fl.under");
        check("fl.err_direct", err, 1'b1);
        wb(2'b00, 0, 0);
        step("fl.sticky");

        // Reset in the middle of traffic with cnt[3]=2
        uop(1'b1, 3'b000, 0, 0, 0, 2'b01, 3, 0, 1'b1);
        step("mr.a");
        step("mr.b");
        reset = 1'b1;
        model_clear(1'b1);
        #1;
        check("mr.ok", chk_ok, 1'b0);
        check_state("mr.async");
        @(posedge clk);
        #1;
        check("mr.ok_hold", chk_ok, 1'b0);
        check_state("mr.hold");
        @(negedge clk);
        reset = 1'b0;
        step("mr.resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

- Parametrised register-hazard scoreboard between the Decode and Data-Fetch/Schedule stages of the core.
- Each architectural register has a saturating pending-write counter, replacing the single occupancy bit per register. Several in-flight writers of one register are therefore tracked correctly.
- Supports up to two destinations per uop (e.g. data register plus RSP), NUM_WB parallel writeback releases, pipeline flush, and an optional same-cycle writeback bypass.

## Interface
Parameters:
- NUM_REGS, 32, number of tracked registers
- IDX_W, $clog2(NUM_REGS), register index width
- CNT_W, 2, pending-counter width; max outstanding writes per register is 2^CNT_W-1
- NUM_SRC, 3, source operands checked per uop
- NUM_WB, 2, writeback release ports

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- chk_valid  in  1  decode presents a uop for check
- chk_src_en  in  NUM_SRC  per-source valid
- chk_src  in  NUM_SRC*IDX_W  source indices, slot i at [i*IDX_W +: IDX_W]
- chk_dst_en  in  2  per-destination valid
- chk_dst  in  2*IDX_W  destination indices
- chk_ok  out  1  combinational: uop may issue this cycle
- issue  in  1  schedule takes the uop; effective claim is fire = chk_valid & chk_ok & issue
- wb_en  in  NUM_WB  writeback release valid
- wb_reg  in  NUM_WB*IDX_W  released register indices
- flush  in  1  branch redirect: drop all pending claims
- busy_mask  out  NUM_REGS  bit r = (cnt[r] != 0)
- idle  out  1  all counters zero
- err  out  1  sticky release-underflow flag

## Operation
- Source hazard for an enabled source s: cnt[s] != 0, or the bypass rule applies (see Configuration).
- Saturation hazard for destination d: cnt[d] + claims[d] > 2^CNT_W-1.
  - claims[d] counts each enabled destination equal to d.
  - Two identical enabled destination indices count once.
- chk_ok = chk_valid & !flush & !reset & no source hazard & no saturation hazard.
- Per-register next value:
  - rel[r] = number of wb ports with wb_en set and wb_reg == r. Duplicate ports count separately.
  - next = cnt + (fire ? claims[r] : 0) - rel[r], computed in CNT_W+2 bits.
  - If the result is negative, clamp to 0 and set err.
- Flush has priority: all counters become 0 on the next edge. Same-cycle fire and wb are discarded, and no err is raised.
- err clears only on reset.
- idle = (busy_mask == 0).

## Timing
- Reset (asynchronous): all counters 0, busy_mask 0, idle 1, err 0. chk_ok is 0 while reset is high.
- chk_ok is combinational from counters, chk_* inputs, flush, and (bypass only) wb_*. No register on this path.
- Counters, busy_mask and idle update at the posedge after fire/wb. Zero latency from claim to busy visibility on the next cycle.
- Back-to-back dependent uops: a consumer is blocked in the cycle after its producer fires. Without bypass it is released the cycle after the producer's wb. With bypass it is released in the wb cycle itself.
- Simultaneous fire and wb on the same register are applied together in one update; the net change may be 0.
- Reset deassertion mid-stream: state stays at zero and operation resumes on the first clk edge.

## Configuration
- SCOREBOARD_BYPASS_EN defined: a source is free when cnt[s] == rel[s] this cycle, i.e. every pending write retires now. The value is taken from the writeback bus by the Data-Fetch stage.
- SCOREBOARD_BYPASS_EN undefined: a source is free only when cnt[s] == 0. wb_* does not feed chk_ok.

## Structure
- The shared package holds NUM_REGS default (GLB_REG_NUM+1) and the register index typedef.
- Sub-module sb_counter holds one register's saturating up/down counter plus its underflow flag. It is instantiated NUM_REGS times.
- The top level holds the decoders, hazard reduction and flush.

## Test plan
- Reset: assert reset mid-traffic with cnt[3]=2 -> busy_mask=0, idle=1, err=0 immediately; chk_ok=0 until deassert.
- RAW: fire uop dst=5; next cycle src=5 -> chk_ok=0; wb_reg=5 -> chk_ok=1 next cycle (same cycle with SCOREBOARD_BYPASS_EN).
- Multi-writer: CNT_W=2, fire dst=7 three times -> cnt[7]=3; fourth check dst=7 -> chk_ok=0; one wb -> chk_ok=1.
- Dual destination: dst0=0, dst1=4 (RSP) -> busy_mask=0x11; dst0=dst1=4 -> cnt[4]=1.
- Simultaneous: cnt[2]=1, fire dst=2 with wb_reg=2 -> cnt[2]=1; two wb ports both reg 2 at cnt 2 -> 0.
- Flush/underflow: flush with fire dst=9 -> cnt all 0, err=0; wb_reg=9 at cnt 0 -> cnt stays 0, err=1 sticky.
